// File: rtl/bsg_alu_pkg.sv
// Shared ALU definitions for bsg_alu and its command issuer.
// Holds the 2-bit ALU control encoding; no ports.
package bsg_alu_pkg;

   localparam int alu_op_w_lp = 2;

   typedef enum logic [alu_op_w_lp-1:0] {
      AND  = 2'b00,
      XOR  = 2'b01,
      NAND = 2'b10,
      ADD  = 2'b11
   } bsg_alu_op_e;

endpackage

// File: rtl/bsg_alu_cmd_issuer_if.sv
// Bundle of all bsg_alu_cmd_issuer bus signals.
// Command (v/ready), ALU drive/return, response (v/yumi) and err flag.
interface bsg_alu_cmd_issuer_if
   import bsg_alu_pkg::*;
#(
   parameter int width_p = 8,
   parameter int tag_p   = 4
);

   logic                   v_i;
   logic                   ready_o;
   logic [alu_op_w_lp-1:0] op_i;
   logic [width_p-1:0]     a_i;
   logic [width_p-1:0]     b_i;
   logic [tag_p-1:0]       tag_i;

   logic [alu_op_w_lp-1:0] alu_control_o;
   logic [width_p-1:0]     alu_a_o;
   logic [width_p-1:0]     alu_b_o;
   logic [width_p-1:0]     alu_res_i;

   logic                   v_o;
   logic                   yumi_i;
   logic [width_p-1:0]     data_o;
   logic [alu_op_w_lp-1:0] op_o;
   logic [tag_p-1:0]       tag_o;
   logic                   err_o;

   // Environment side: command producer, external ALU, response consumer.
   modport master (
      output v_i, op_i, a_i, b_i, tag_i,
      output alu_res_i, yumi_i,
      input  ready_o, alu_control_o, alu_a_o, alu_b_o,
      input  v_o, data_o, op_o, tag_o, err_o
   );

   // Issuer side.
   modport slave (
      input  v_i, op_i, a_i, b_i, tag_i,
      input  alu_res_i, yumi_i,
      output ready_o, alu_control_o, alu_a_o, alu_b_o,
      output v_o, data_o, op_o, tag_o, err_o
   );

endinterface

// File: rtl/bsg_alu_cmd_issuer_rsp_fifo.sv
// In-order response buffer, els_p entries, circular read/write pointers.
// Ports: clk_i, reset_n_i, push_i/data_i, pop_i, v_o/data_o head, count_o.
module bsg_alu_cmd_issuer_rsp_fifo #(
   parameter int width_p = 14,
   parameter int els_p   = 4,
   localparam int cnt_w_lp = $clog2(els_p + 1)
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                push_i,
   input  logic [width_p-1:0]  data_i,
   input  logic                pop_i,
   output logic                v_o,
   output logic [width_p-1:0]  data_o,
   output logic [cnt_w_lp-1:0] count_o
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);

   logic [width_p-1:0]  mem [els_p];
   logic [ptr_w_lp-1:0] wr_ptr;
   logic [ptr_w_lp-1:0] rd_ptr;
   logic [cnt_w_lp-1:0] count_r;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < els_p; i++) begin
            mem[i] <= '0;
         end
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_r <= '0;
      end else begin
         if (push_i) begin
            mem[wr_ptr] <= data_i;
            wr_ptr <= (wr_ptr == last_lp) ? '0 : wr_ptr + 1'b1;
         end
         if (pop_i) begin
            rd_ptr <= (rd_ptr == last_lp) ? '0 : rd_ptr + 1'b1;
         end
         // Simultaneous push and pop leave occupancy unchanged.
         count_r <= count_r + cnt_w_lp'(push_i) - cnt_w_lp'(pop_i);
      end
   end

   assign v_o     = (count_r != '0);
   assign data_o  = mem[rd_ptr];
   assign count_o = count_r;

endmodule

// File: rtl/bsg_alu_cmd_issuer.sv
// Initiator for a combinational ALU: issues commands, returns results in order.
// Ports: clk_i, reset_n_i (async, active low), io (slave: cmd, alu, rsp, err).
// Optional: BSG_ALU_CMD_ISSUER_CHECK_EN adds a reference model driving err_o.
module bsg_alu_cmd_issuer
   import bsg_alu_pkg::*;
#(
   parameter int width_p = 8,
   parameter int els_p   = 4,
   parameter int tag_p   = 4
) (
   input  logic clk_i,
   input  logic reset_n_i,
   bsg_alu_cmd_issuer_if.slave io
);

   localparam int ent_w_lp = width_p + alu_op_w_lp + tag_p;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   logic                iss_v;
   bsg_alu_op_e         iss_op;
   logic [width_p-1:0]  iss_a;
   logic [width_p-1:0]  iss_b;
   logic [tag_p-1:0]    iss_tag;

   logic                accept;
   logic                pop;
   logic                fifo_v;
   logic [ent_w_lp-1:0] push_ent;
   logic [ent_w_lp-1:0] head_ent;
   logic [cnt_w_lp-1:0] count;
   logic [cnt_w_lp:0]   load;

   // Reserve a slot for the command already sitting in the issue reg,
   // so the buffer can never overflow. Registers only feed ready_o.
   assign load       = {1'b0, count} + {{cnt_w_lp{1'b0}}, iss_v};
   assign io.ready_o = (load < (cnt_w_lp + 1)'(els_p));
   assign accept     = io.v_i & io.ready_o;
   // Illegal yumi with nothing valid is ignored.
   assign pop        = io.yumi_i & fifo_v;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         iss_v   <= 1'b0;
         iss_op  <= AND;
         iss_a   <= '0;
         iss_b   <= '0;
         iss_tag <= '0;
      end else begin
         iss_v <= accept;
         if (accept) begin
            iss_op  <= bsg_alu_op_e'(io.op_i);
            iss_a   <= io.a_i;
            iss_b   <= io.b_i;
            iss_tag <= io.tag_i;
         end
      end
   end

   // Issue reg holds its last command while idle.
   assign io.alu_control_o = iss_op;
   assign io.alu_a_o       = iss_a;
   assign io.alu_b_o       = iss_b;

   assign push_ent = {io.alu_res_i, iss_op, iss_tag};

   bsg_alu_cmd_issuer_rsp_fifo #(
      .width_p (ent_w_lp),
      .els_p   (els_p)
   ) rsp_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (iss_v),
      .data_i    (push_ent),
      .pop_i     (pop),
      .v_o       (fifo_v),
      .data_o    (head_ent),
      .count_o   (count)
   );

   assign io.v_o = fifo_v;
   assign {io.data_o, io.op_o, io.tag_o} = head_ent;

`ifdef BSG_ALU_CMD_ISSUER_CHECK_EN
   logic [width_p-1:0] exp_res;
   logic               err_r;

   always_comb begin
      exp_res = '0;
      unique case (iss_op)
         AND:  exp_res = iss_a & iss_b;
         XOR:  exp_res = iss_a ^ iss_b;
         NAND: exp_res = ~(iss_a & iss_b);
         ADD:  exp_res = iss_a + iss_b;
      endcase
   end

   // Sticky until reset.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         err_r <= 1'b0;
      end else if (iss_v && (io.alu_res_i != exp_res)) begin
         err_r <= 1'b1;
      end
   end

   assign io.err_o = err_r;
`else
   assign io.err_o = 1'b0;
`endif

   yumi_legal: assert property (
      @(posedge clk_i) disable iff (!reset_n_i) io.yumi_i |-> fifo_v
   );

endmodule

// File: tb/tb_bsg_alu_cmd_issuer.sv
// Self-checking bench for bsg_alu_cmd_issuer (width 8, 4 entries, tag 4).
// Directed table, multi-cycle corner sequences and random traffic vs a queue model.
module tb_bsg_alu_cmd_issuer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic force_en = 1'b0;
   logic [7:0] force_val = 8'h00;

   int vecs = 0;
   int miscompares = 0;
   int pops = 0;

   always #5 clk = ~clk;

   bsg_alu_cmd_issuer_if #(.width_p(8), .tag_p(4)) io ();

   bsg_alu_cmd_issuer #(
      .width_p (8),
      .els_p   (4),
      .tag_p   (4)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .io        (io)
   );

   function automatic logic [7:0] model(logic [1:0] op, logic [7:0] a, logic [7:0] b);
      int s;
      case (op)
         2'd0: return a & b;
         2'd1: return a ^ b;
         2'd2: return ~(a & b);
         default: begin
            s = (int'(a) + int'(b)) % 256;
            return s[7:0];
         end
      endcase
   endfunction

   // External combinational ALU, with a fault-injection override.
   always_comb begin
      io.alu_res_i = model(io.alu_control_o, io.alu_a_o, io.alu_b_o);
      if (force_en) io.alu_res_i = force_val;
   end

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] op;
      logic [3:0] tag;
   } rsp_t;

   typedef struct {
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] tag;
      logic [7:0] exp;
   } vec_t;

   rsp_t q[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs are already set; record handshakes, then advance one cycle.
   task automatic cycle();
      bit acc, pp;
      rsp_t e;
      acc = io.v_i && io.ready_o;
      pp  = io.v_o && io.yumi_i;
      if (pp) begin
         pops++;
         if (q.size() == 0) chk("unexpected_rsp", 1, 0);
         else begin
            e = q.pop_front();
            chk("rsp", {io.data_o, io.op_o, io.tag_o}, e);
         end
      end
      if (acc) q.push_back({model(io.op_i, io.a_i, io.b_i), io.op_i, io.tag_i});
      @(posedge clk);
      #1;
   endtask

   task automatic rand_cmd(bit v);
      io.v_i   = v;
      io.op_i  = 2'($urandom_range(0, 3));
      io.a_i   = 8'($urandom);
      io.b_i   = 8'($urandom);
      io.tag_i = 4'($urandom);
   endtask

   task automatic drain();
      int n;
      io.v_i = 1'b0;
      n = 0;
      while ((q.size() != 0 || io.v_o) && n < 50) begin
         io.yumi_i = io.v_o;
         cycle();
         n++;
      end
      io.yumi_i = 1'b0;
      chk("drain_done", (n < 50) ? 1 : 0, 1);
   endtask

   initial begin
      vec_t tbl[6];
      int n, first, last, sent;
      logic [13:0] held;
      logic exp_err;

      tbl[0] = '{2'b00, 8'hF0, 8'h3C, 4'h5, 8'h30};
      tbl[1] = '{2'b11, 8'hFF, 8'h02, 4'h1, 8'h01};
      tbl[2] = '{2'b10, 8'hFF, 8'h0F, 4'h2, 8'hF0};
      tbl[3] = '{2'b01, 8'hAA, 8'h55, 4'hA, 8'hFF};
      tbl[4] = '{2'b11, 8'h80, 8'h80, 4'hF, 8'h00};
      tbl[5] = '{2'b10, 8'h00, 8'h00, 4'h0, 8'hFF};

      io.v_i = 1'b0; io.op_i = '0; io.a_i = '0; io.b_i = '0;
      io.tag_i = '0; io.yumi_i = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      chk("rst_ready", io.ready_o, 1);
      chk("rst_v_o", io.v_o, 0);
      chk("rst_data", {io.data_o, io.op_o, io.tag_o}, 0);
      chk("rst_alu", {io.alu_control_o, io.alu_a_o, io.alu_b_o}, 0);
      chk("rst_err", io.err_o, 0);

      // Directed table: latency, ALU drive and result per command.
      for (int i = 0; i < 6; i++) begin
         chk("tbl_ready", io.ready_o, 1);
         io.v_i = 1'b1; io.op_i = tbl[i].op; io.a_i = tbl[i].a;
         io.b_i = tbl[i].b; io.tag_i = tbl[i].tag;
         cycle();
         io.v_i = 1'b0;
         chk("tbl_alu", {io.alu_control_o, io.alu_a_o, io.alu_b_o},
             {tbl[i].op, tbl[i].a, tbl[i].b});
         chk("tbl_v_c1", io.v_o, 0);
         cycle();
         chk("tbl_v_c2", io.v_o, 1);
         chk("tbl_data", {io.data_o, io.op_o, io.tag_o},
             {tbl[i].exp, tbl[i].op, tbl[i].tag});
         io.yumi_i = 1'b1;
         cycle();
         io.yumi_i = 1'b0;
         chk("tbl_v_after", io.v_o, 0);
         chk("tbl_alu_hold", {io.alu_control_o, io.alu_a_o}, {tbl[i].op, tbl[i].a});
      end

      // Backpressure: fill, stall, one yumi reopens ready.
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (!io.ready_o) break;
         rand_cmd(1'b1);
         cycle();
         n++;
      end
      io.v_i = 1'b0;
      chk("bp_accepts", n, 4);
      held = {io.data_o, io.op_o, io.tag_o};
      cycle();
      chk("bp_ready_low", io.ready_o, 0);
      chk("bp_stable", {io.data_o, io.op_o, io.tag_o}, held);
      io.yumi_i = 1'b1;
      cycle();
      io.yumi_i = 1'b0;
      chk("bp_ready_back", io.ready_o, 1);
      drain();

      // Streaming: 8 back-to-back commands, consumer always ready.
      pops = 0; first = -1; last = -1; sent = 0;
      for (int k = 0; k < 20; k++) begin
         if (sent < 8) begin
            rand_cmd(1'b1);
            chk("stream_ready", io.ready_o, 1);
         end else io.v_i = 1'b0;
         io.yumi_i = io.v_o;
         if (io.v_o) begin
            if (first < 0) first = k;
            last = k;
         end
         if (io.v_i && io.ready_o) sent++;
         cycle();
      end
      io.yumi_i = 1'b0;
      chk("stream_first", first, 2);
      chk("stream_span", last - first, 7);
      chk("stream_pops", pops, 8);

      // Reset with two commands in flight.
      for (int k = 0; k < 2; k++) begin
         rand_cmd(1'b1);
         cycle();
      end
      io.v_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_v_o", io.v_o, 0);
      chk("mid_rst_data", io.data_o, 0);
      q.delete();
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         chk("post_rst_v_o", io.v_o, 0);
         chk("post_rst_ready", io.ready_o, 1);
         cycle();
      end

      // Random traffic against the queue model.
      for (int k = 0; k < 400; k++) begin
         rand_cmd($urandom_range(0, 3) != 0);
         io.yumi_i = io.v_o && ($urandom_range(0, 2) != 0);
         cycle();
      end
      drain();
      chk("rand_empty", q.size(), 0);
      chk("no_err", io.err_o, 0);

      // Corrupted ALU result.
`ifdef BSG_ALU_CMD_ISSUER_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      io.v_i = 1'b1; io.op_i = 2'b01; io.a_i = 8'hAA; io.b_i = 8'h55;
      io.tag_i = 4'h3;
      cycle();
      io.v_i = 1'b0;
      q.delete();
      q.push_back({8'hFE, 2'b01, 4'h3});
      force_en = 1'b1; force_val = 8'hFE;
      chk("err_before", io.err_o, 0);
      cycle();
      force_en = 1'b0;
      chk("err_set", io.err_o, exp_err);
      chk("err_data", io.data_o, 8'hFE);
      io.yumi_i = 1'b1;
      cycle();
      io.yumi_i = 1'b0;
      repeat (2) cycle();
      chk("err_held", io.err_o, exp_err);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
